// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encodings and default constants for the CNN frame control path
package cnn_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;
  localparam int CNN_RESULT_W       = 5;
  localparam int CNN_FLUSH_CYCLES   = 8;
  localparam int CNN_TIMEOUT_W      = 20;
  localparam int CNN_TIMEOUT_CYCLES = 800000;
  localparam int CNN_FCNT_W         = 16;
endpackage

// File: rtl/cnn_watchdog.sv
// cnn_watchdog: clearable enabled counter flagging the enabled cycle that completes LIMIT counts
module cnn_watchdog #(
  parameter int W     = 20,
  parameter int LIMIT = 800000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  assign tc = en && cnt == W'(LIMIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: per-frame flush/run/drain/handoff controller for the CNN pipeline
module cnn_frame_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES   = CNN_FLUSH_CYCLES,
  parameter int TIMEOUT_W      = CNN_TIMEOUT_W,
  parameter int TIMEOUT_CYCLES = CNN_TIMEOUT_CYCLES,
  parameter int RESULT_W       = CNN_RESULT_W,
  parameter int FCNT_W         = CNN_FCNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_pool1_end,
  input  logic                i_pool2_end,
  input  logic                i_result_valid,
  input  logic [RESULT_W-1:0] i_result_data,
  input  logic                i_res_ready,
  output logic                o_pipe_en,
  output logic                o_pipe_clr,
  output logic                o_busy,
  output logic                o_res_valid,
  output logic [RESULT_W-1:0] o_res_data,
  output logic [FCNT_W-1:0]   o_frame_cnt,
  output logic                o_timeout_err,
  output logic [2:0]          o_state
);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  state_t state, state_n;
  logic start_ok, run_en, flush_done, wd_tc, pool1_seen, take_res;
  assign start_ok = state == ST_IDLE && i_start;
  assign run_en   = state == ST_RUN || state == ST_DRAIN;
  assign take_res = run_en && state_n == ST_HOLD;
  cnn_watchdog #(.W(FLUSH_W), .LIMIT(FLUSH_CYCLES)) u_flush (
    .clk(clk), .rst(rst), .load(start_ok), .en(state == ST_FLUSH), .tc(flush_done)
  );
  cnn_watchdog #(.W(TIMEOUT_W), .LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk(clk), .rst(rst), .load(start_ok), .en(run_en), .tc(wd_tc)
  );
  // priority within a cycle: abort, timeout, result, pool2_end
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  state_n = i_start ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: state_n = i_abort ? ST_ERR : flush_done ? ST_RUN : ST_FLUSH;
      ST_RUN:   state_n = i_abort || wd_tc ? ST_ERR : i_result_valid ? ST_HOLD :
                          i_pool2_end && pool1_seen ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_n = i_abort || wd_tc ? ST_ERR : i_result_valid ? ST_HOLD : ST_DRAIN;
      ST_HOLD:  state_n = i_res_ready ? ST_IDLE : ST_HOLD;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= ST_IDLE;
      o_state       <= '0;
      o_pipe_en     <= 1'b0;
      o_pipe_clr    <= 1'b0;
      o_busy        <= 1'b0;
      o_res_valid   <= 1'b0;
      o_res_data    <= '0;
      o_frame_cnt   <= '0;
      o_timeout_err <= 1'b0;
      pool1_seen    <= 1'b0;
    end else begin
      state         <= state_n;
      o_state       <= state_n;
      o_pipe_en     <= state_n == ST_RUN || state_n == ST_DRAIN;
      o_pipe_clr    <= state_n == ST_FLUSH || state_n == ST_ERR;
      o_busy        <= state_n != ST_IDLE;
      o_res_valid   <= state_n == ST_HOLD;
      pool1_seen    <= start_ok ? 1'b0 : (state == ST_RUN && i_pool1_end) | pool1_seen;
      o_timeout_err <= start_ok ? 1'b0 : (wd_tc && !i_abort) | o_timeout_err;
      if (take_res) begin
        o_res_data  <= i_result_data;
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: randomized frame scenarios checked against an event-order outcome model
module tb_cnn_frame_sequencer;
  localparam int F  = 8;
  localparam int T  = 1000;
  localparam int RW = 5;
  localparam int CW = 2;
  logic clk = 0, rst = 1;
  logic i_start = 0, i_abort = 0, i_pool1_end = 0, i_pool2_end = 0, i_result_valid = 0, i_res_ready = 0;
  logic [RW-1:0] i_result_data = '0;
  logic o_pipe_en, o_pipe_clr, o_busy, o_res_valid, o_timeout_err;
  logic [RW-1:0] o_res_data;
  logic [CW-1:0] o_frame_cnt;
  logic [2:0] o_state;
  int errors = 0, checks = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic exp_terr = 1'b0;
  logic [RW-1:0] exp_data = '0;
  cnn_frame_sequencer #(
    .FLUSH_CYCLES(F), .TIMEOUT_W(20), .TIMEOUT_CYCLES(T), .RESULT_W(RW), .FCNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_pool1_end(i_pool1_end),
    .i_pool2_end(i_pool2_end), .i_result_valid(i_result_valid), .i_result_data(i_result_data),
    .i_res_ready(i_res_ready), .o_pipe_en(o_pipe_en), .o_pipe_clr(o_pipe_clr), .o_busy(o_busy),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_frame_cnt(o_frame_cnt),
    .o_timeout_err(o_timeout_err), .o_state(o_state)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
  function automatic logic [6:0] vec(input logic [2:0] s);
    return {s, s == 3'd2 || s == 3'd3, s == 3'd1 || s == 3'd5, s != 3'd0, s == 3'd4};
  endfunction
  function automatic logic [6:0] obs();
    return {o_state, o_pipe_en, o_pipe_clr, o_busy, o_res_valid};
  endfunction
  task automatic clear_inputs();
    i_start = 0; i_abort = 0; i_pool1_end = 0; i_pool2_end = 0; i_result_valid = 0; i_res_ready = 0;
  endtask
  // one frame: event offsets k counted from the first cycle with o_pipe_en=1; -1 means never
  task automatic do_frame(input int p1, input int p2, input int rv, input int ab,
                          input int rdy_wait, input logic [RW-1:0] d, input int rst_k);
    int end_k, kind, drain_k;
    end_k = T - 1; kind = 1;
    if (rv >= 0 && rv < end_k) begin end_k = rv; kind = 2; end
    if (ab >= 0 && ab <= end_k) begin end_k = ab; kind = 0; end
    drain_k = (p1 >= 0 && p2 > p1 && p2 < end_k) ? p2 + 1 : 32'h7fff_ffff;
    checks++;
    if (obs() !== vec(3'd0)) begin errors++; $display("FAIL idle_before_start: got %b want %b", obs(), vec(3'd0)); end
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    exp_terr = 1'b0;
    checks++;
    if (o_timeout_err !== 1'b0) begin errors++; $display("FAIL terr_clear_on_start: got %b want 0", o_timeout_err); end
    for (int i = 0; i < F; i++) begin
      checks++;
      if (obs() !== vec(3'd1)) begin errors++; $display("FAIL flush_cycle%0d: got %b want %b", i, obs(), vec(3'd1)); end
      @(negedge clk);
    end
    for (int k = 0; k <= end_k; k++) begin
      checks++;
      if (obs() !== vec(k >= drain_k ? 3'd3 : 3'd2)) begin
        errors++; $display("FAIL run_k%0d: got %b want %b", k, obs(), vec(k >= drain_k ? 3'd3 : 3'd2));
      end
      if (k == rst_k) begin
        rst = 1;
        #1;
        exp_cnt = '0; exp_terr = 0; exp_data = '0;
        checks++;
        if ({obs(), o_res_data, o_frame_cnt, o_timeout_err} !== '0) begin
          errors++; $display("FAIL async_reset: got %b want 0", {obs(), o_res_data, o_frame_cnt, o_timeout_err});
        end
        clear_inputs();
        @(negedge clk);
        rst = 0;
        return;
      end
      i_pool1_end = k == p1; i_pool2_end = k == p2; i_result_valid = k == rv; i_abort = k == ab;
      i_result_data = k == rv ? d : RW'($urandom);
      @(negedge clk);
    end
    clear_inputs();
    if (kind == 2) begin
      exp_cnt++; exp_data = d;
      for (int i = 0; i <= rdy_wait; i++) begin
        checks++;
        if ({obs(), o_res_data, o_frame_cnt} !== {vec(3'd4), exp_data, exp_cnt}) begin
          errors++; $display("FAIL hold%0d: got %b want %b", i, {obs(), o_res_data, o_frame_cnt}, {vec(3'd4), exp_data, exp_cnt});
        end
        i_res_ready = i == rdy_wait;
        i_start = i < rdy_wait && $urandom_range(0, 1) == 1;
        i_abort = i < rdy_wait && $urandom_range(0, 1) == 1;
        @(negedge clk);
      end
      clear_inputs();
    end else begin
      exp_terr = kind == 1;
      checks++;
      if ({obs(), o_timeout_err} !== {vec(3'd5), exp_terr}) begin
        errors++; $display("FAIL err_state: got %b want %b", {obs(), o_timeout_err}, {vec(3'd5), exp_terr});
      end
      @(negedge clk);
    end
    checks++;
    if ({obs(), o_res_data, o_frame_cnt, o_timeout_err} !== {vec(3'd0), exp_data, exp_cnt, exp_terr}) begin
      errors++; $display("FAIL frame_end: got %b want %b", {obs(), o_res_data, o_frame_cnt, o_timeout_err},
                         {vec(3'd0), exp_data, exp_cnt, exp_terr});
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({obs(), o_res_data, o_frame_cnt, o_timeout_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {obs(), o_res_data, o_frame_cnt, o_timeout_err});
    end
    rst = 0;
    i_abort = 1;
    repeat (3) @(negedge clk);
    i_abort = 0;
    checks++;
    if (obs() !== vec(3'd0)) begin errors++; $display("FAIL abort_in_idle: got %b want %b", obs(), vec(3'd0)); end
  endtask
  task automatic test_normal();
    do_frame(100 - F - 1, 200 - F - 1, 230 - F - 1, -1, 0, 5'd7, -1);
  endtask
  task automatic test_backpressure();
    do_frame(10, 30, 45, -1, 50, 5'd21, -1);
  endtask
  task automatic test_timeout();
    do_frame(5, -1, -1, -1, 0, 5'd0, -1);
    do_frame(3, 8, 12, -1, 1, 5'd9, -1);
  endtask
  task automatic test_abort_priority();
    do_frame(3, 10, 20, 20, 0, 5'd31, -1);
    @(negedge clk);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    repeat (3) @(negedge clk);
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;
    checks++;
    if (obs() !== vec(3'd5)) begin errors++; $display("FAIL abort_in_flush: got %b want %b", obs(), vec(3'd5)); end
    @(negedge clk);
    checks++;
    if ({obs(), o_frame_cnt, o_timeout_err} !== {vec(3'd0), exp_cnt, 1'b0}) begin
      errors++; $display("FAIL after_flush_abort: got %b want %b", {obs(), o_frame_cnt, o_timeout_err}, {vec(3'd0), exp_cnt, 1'b0});
    end
  endtask
  task automatic test_ordering();
    do_frame(10, 5, 25, -1, 0, 5'd12, -1);
    do_frame(4, 9, 9, -1, 2, 5'd3, -1);
  endtask
  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int p1, p2, rv, ab;
      p1 = $urandom_range(0, 40);
      p2 = $urandom_range(0, 60);
      if (p2 == p1) p2 = p1 + 1;
      rv = $urandom_range(0, 80);
      ab = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 80)) : -1;
      do_frame(p1, p2, rv, ab, $urandom_range(0, 5), RW'($urandom), -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask
  task automatic test_reset_wrap();
    do_frame(2, 5, -1, -1, 0, 5'd0, 10);
    for (int n = 0; n < 5; n++) do_frame(1, 3, 5, -1, 0, RW'(n + 1), -1);
    checks++;
    if (o_frame_cnt !== 2'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", o_frame_cnt); end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_abort_priority();
    test_ordering();
    test_random();
    test_reset_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
